// File: rtl/aes_128_pkg.sv
// Shared types and default constants for the AES-128 core arbiter.
package aes_128_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int N_REQ_DEFAULT   = 2;
    localparam int TIMEOUT_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin port selection.
// The search starts one past last_grant and wraps modulo N.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [IDX_W:0] cand;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int off = 1; off <= N; off++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!any_grant && req[cand[IDX_W-1:0]]) begin
                grant_idx = cand[IDX_W-1:0];
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_128_arbiter.sv
// Shares one multicycle AES-128 core among N_REQ requesters, one job at a time.
// Includes a watchdog that answers with rsp_err when the core never completes.
module aes_128_arbiter
    import aes_128_pkg::*;
#(
    parameter  int N_REQ   = N_REQ_DEFAULT,
    parameter  int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int WD_W    = $clog2(TIMEOUT)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req_valid,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic [N_REQ-1:0][AES_BLOCK_W-1:0]   req_data,
    input  logic [N_REQ-1:0][AES_BLOCK_W-1:0]   req_key,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [AES_BLOCK_W-1:0]              rsp_data,
    output logic [ID_W-1:0]                     rsp_id,
    output logic                                rsp_err,
    output logic [AES_BLOCK_W-1:0]              core_in_bus,
    output logic [AES_BLOCK_W-1:0]              core_key,
    input  logic [AES_BLOCK_W-1:0]              core_out_bus,
    input  logic                                core_valid_ready,
    output logic                                busy
);

    arb_state_t             state, state_next;
    logic [ID_W-1:0]        last_grant, hold_id, grant_idx;
    logic [AES_BLOCK_W-1:0] hold_data, hold_key;
    logic [WD_W-1:0]        wd_cnt;
    logic                   seen_low, hold_off, any_grant;
    logic                   grant, done, expired;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    // NOTE: rst gates the grant combinationally so req_ready is 0 for the whole reset, not just after an edge.
    assign grant   = (state == IDLE) && !hold_off && any_grant && !rst;
    assign done    = core_valid_ready && seen_low;
    assign expired = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign rsp_id  = hold_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        rsp_valid   = 1'b0;
        busy        = (state != IDLE);
        core_in_bus = '0;
        core_key    = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = ISSUE;
                end
            end
            ISSUE: begin
                core_in_bus = hold_data;
                core_key    = hold_key;
                if (core_valid_ready) state_next = WAIT;
            end
            WAIT: begin
                core_in_bus = hold_data;
                core_key    = hold_key;
                if (done || expired) state_next = RESP;
            end
            RESP: begin
                core_in_bus = hold_data;
                core_key    = hold_key;
                rsp_valid   = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // hold_off blocks the grant in the first IDLE cycle after a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= ID_W'(N_REQ - 1);
            hold_id    <= '0;
            hold_data  <= '0;
            hold_key   <= '0;
            seen_low   <= 1'b0;
            wd_cnt     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            hold_off   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold_off <= 1'b0;
                    if (grant) begin
                        hold_data  <= req_data[grant_idx];
                        hold_key   <= req_key[grant_idx];
                        hold_id    <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                ISSUE: begin
                    if (core_valid_ready) begin
                        seen_low <= 1'b0;
                        wd_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (!core_valid_ready) seen_low <= 1'b1;
                    if (done) begin
                        rsp_data <= core_out_bus;
                        rsp_err  <= 1'b0;
                    end else if (expired) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) hold_off <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_arbiter.sv
// Self-checking bench for aes_128_arbiter with a behavioural AES-128 core model.
// Expected responses are queued at each accepted request and checked as responses leave.
module tb_aes_128_arbiter;

    localparam int N       = 2;
    localparam int TIMEOUT = 32;
    localparam int LAT     = 4;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
    } job_t;

    typedef struct {
        logic [0:0]   id;
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid, req_ready;
    logic [N-1:0][127:0]   req_data, req_key;
    logic                  rsp_valid, rsp_ready, rsp_err, busy;
    logic [127:0]          rsp_data, core_in_bus, core_key, core_out_bus;
    logic [0:0]            rsp_id;
    logic                  core_valid_ready;

    int tests_run = 0, tests_failed = 0;
    int cyc = 0, rsp_count = 0, multi_grant = 0;
    int grant_cyc = 0, rsp_start_cyc = 0;
    int grant_log[$], id_log[$];
    job_t job_q0[$], job_q1[$];
    exp_t exp_q[$];
    exp_t mon_e;
    logic rsp_prev = 1'b0, core_hang = 1'b0;
    logic [127:0] last_rsp_data;
    logic [0:0]   last_rsp_id;

    aes_128_arbiter #(.N_REQ(N), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_data         (req_data),
        .req_key          (req_key),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_id           (rsp_id),
        .rsp_err          (rsp_err),
        .core_in_bus      (core_in_bus),
        .core_key         (core_key),
        .core_out_bus     (core_out_bus),
        .core_valid_ready (core_valid_ready),
        .busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr + 4*((c+rr)%4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- core model ----------------
    logic         core_armed, core_busy;
    int           core_cnt;
    logic [127:0] core_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_valid_ready <= 1'b1;
            core_armed       <= 1'b0;
            core_busy        <= 1'b0;
            core_cnt         <= 0;
            core_res         <= '0;
            core_out_bus     <= '0;
        end else if (|(req_valid & req_ready)) begin
            core_armed <= 1'b1;
        end else if (core_armed && core_valid_ready && !core_busy) begin
            core_armed       <= 1'b0;
            core_busy        <= 1'b1;
            core_valid_ready <= 1'b0;
            core_cnt         <= LAT - 1;
            core_res         <= aes_enc(core_in_bus, core_key);
            core_out_bus     <= {4{32'hdeadbeef}};
        end else if (core_busy && !core_hang) begin
            if (core_cnt == 1) begin
                core_valid_ready <= 1'b1;
                core_busy        <= 1'b0;
                core_out_bus     <= core_res;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // ---------------- requester driver ----------------
    initial begin
        logic [N-1:0] hs;
        req_valid = '0;
        req_data  = '0;
        req_key   = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (rst) begin
                req_valid = '0;
                job_q0.delete();
                job_q1.delete();
            end else begin
                if (hs[0]) begin job_q0.delete(0); req_valid[0] = 1'b0; end
                if (hs[1]) begin job_q1.delete(0); req_valid[1] = 1'b0; end
                if (!req_valid[0] && job_q0.size() > 0) begin
                    req_valid[0] = 1'b1; req_data[0] = job_q0[0].pt; req_key[0] = job_q0[0].key;
                end
                if (!req_valid[1] && job_q1.size() > 0) begin
                    req_valid[1] = 1'b1; req_data[1] = job_q1[0].pt; req_key[1] = job_q1[0].key;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rsp_prev = 1'b0;
        end else begin
            if ($countones(req_ready) > 1) multi_grant++;
            if (rsp_valid && !rsp_prev) rsp_start_cyc = cyc;
            rsp_prev = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_extra: unexpected response id %0d data %h", rsp_id, rsp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rsp_id !== mon_e.id || rsp_data !== mon_e.data || rsp_err !== mon_e.err) begin
                        tests_failed++;
                        $display("FAIL scoreboard: got id %0d err %0b data %h, expected id %0d err %0b data %h",
                                 rsp_id, rsp_err, rsp_data, mon_e.id, mon_e.err, mon_e.data);
                    end
                end
                rsp_count++;
                id_log.push_back(int'(rsp_id));
                last_rsp_data = rsp_data;
                last_rsp_id   = rsp_id;
            end
            for (int p = 0; p < N; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    grant_log.push_back(p);
                    grant_cyc  = cyc;
                    mon_e.id   = 1'(p);
                    mon_e.err  = core_hang;
                    mon_e.data = core_hang ? 128'h0 : aes_enc(req_data[p], req_key[p]);
                    exp_q.push_back(mon_e);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic job_t rand_job();
        job_t j;
        j.pt  = {$urandom, $urandom, $urandom, $urandom};
        j.key = {$urandom, $urandom, $urandom, $urandom};
        return j;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        grant_log.delete();
        id_log.delete();
        multi_grant = 0;
    endtask

    task automatic wait_rsps(input int target, input string name);
        int n;
        n = 0;
        while (rsp_count < target && n < 500) begin @(negedge clk); n++; end
        #1;
        tests_run++;
        if (rsp_count < target) begin
            tests_failed++;
            $display("FAIL %s: responses got %0d expected %0d (timed out)", name, rsp_count, target);
        end
    endtask

    task automatic wait_rsp_valid(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        #1;
        tests_run++;
        if (!rsp_valid) begin
            tests_failed++;
            $display("FAIL %s: rsp_valid got 0 expected 1 (timed out)", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({rsp_valid, req_ready, busy, rsp_err, rsp_id} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0", {rsp_valid, req_ready, busy, rsp_err, rsp_id});
        end
        tests_run++;
        if ({rsp_data, core_in_bus, core_key} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: rsp_data %h core_in_bus %h core_key %h expected 0", rsp_data, core_in_bus, core_key);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, rsp_valid, req_ready} !== '0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b expected 0", {busy, rsp_valid, req_ready});
        end
    endtask

    task automatic test_fips_vector();
        job_t j;
        int   base;
        j.key = 128'h000102030405060708090a0b0c0d0e0f;
        j.pt  = 128'h00112233445566778899aabbccddeeff;
        base  = rsp_count;
        @(negedge clk);
        job_q0.push_back(j);
        wait_rsps(base + 1, "fips_done");
        tests_run++;
        if (last_rsp_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || last_rsp_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL fips_vector: got id %0d data %h expected id 0 data 69c4e0d86a7b0430d8cdb78070b4c55a",
                     last_rsp_id, last_rsp_data);
        end
        tests_run++;
        if (rsp_start_cyc - grant_cyc !== LAT + 2) begin
            tests_failed++;
            $display("FAIL min_latency: got %0d cycles expected %0d", rsp_start_cyc - grant_cyc, LAT + 2);
        end
    endtask

    task automatic test_round_robin();
        int base;
        do_reset();
        base = rsp_count;
        @(negedge clk);
        job_q0.push_back(rand_job());
        job_q0.push_back(rand_job());
        job_q1.push_back(rand_job());
        job_q1.push_back(rand_job());
        wait_rsps(base + 4, "rr_done");
        tests_run++;
        if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
            tests_failed++;
            $display("FAIL rr_grant_order: got %p expected 0,1,0,1", grant_log);
        end
        tests_run++;
        if (id_log.size() != 4 || id_log[0] != 0 || id_log[1] != 1 || id_log[2] != 0 || id_log[3] != 1) begin
            tests_failed++;
            $display("FAIL rr_rsp_id_order: got %p expected 0,1,0,1", id_log);
        end
        tests_run++;
        if (multi_grant !== 0) begin
            tests_failed++;
            $display("FAIL rr_single_ready: got %0d multi-port cycles expected 0", multi_grant);
        end
    endtask

    task automatic test_back_pressure();
        int base, bad, n0, rise_cyc, n;
        logic [127:0] held;
        base = rsp_count;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        job_q0.push_back(rand_job());
        wait_rsp_valid("stall_rsp");
        held = rsp_data;
        job_q1.push_back(rand_job());
        n0  = grant_log.size();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== held || req_ready !== '0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        rise_cyc  = cyc;
        n = 0;
        while (grant_log.size() == n0 && n < 20) begin @(negedge clk); n++; end
        #1;
        tests_run++;
        if (grant_log.size() == n0 || grant_cyc - rise_cyc !== 2 || grant_log[n0] != 1) begin
            tests_failed++;
            $display("FAIL regrant_delay: got %0d cycles (grants %0d) expected 2 on port 1", grant_cyc - rise_cyc, grant_log.size() - n0);
        end
        wait_rsps(base + 2, "stall_done");
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        core_hang = 1'b1;
        base = rsp_count;
        @(negedge clk);
        job_q0.push_back(rand_job());
        wait_rsp_valid("timeout_rsp");
        tests_run++;
        if (rsp_start_cyc - grant_cyc !== TIMEOUT + 2) begin
            tests_failed++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", rsp_start_cyc - grant_cyc, TIMEOUT + 2);
        end
        tests_run++;
        if (rsp_err !== 1'b1 || rsp_data !== 128'h0) begin
            tests_failed++;
            $display("FAIL timeout_err: got err %0b data %h expected err 1 data 0", rsp_err, rsp_data);
        end
        wait_rsps(base + 1, "timeout_done");
        core_hang = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int base, n;
        do_reset();
        core_hang = 1'b1;
        @(negedge clk);
        job_q0.push_back(rand_job());
        n = 0;
        while (grant_log.size() == 0 && n < 20) begin @(negedge clk); n++; end
        repeat (5) @(posedge clk);
        #1;
        base = rsp_count;
        rst  = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({rsp_valid, req_ready, busy, rsp_err, rsp_id} !== '0 || {rsp_data, core_in_bus, core_key} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got ctrl %b data %h in %h key %h expected 0",
                     {rsp_valid, req_ready, busy, rsp_err, rsp_id}, rsp_data, core_in_bus, core_key);
        end
        core_hang = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        grant_log.delete();
        @(negedge clk);
        job_q1.push_back(rand_job());
        job_q0.push_back(rand_job());
        wait_rsps(base + 2, "post_reset_done");
        repeat (10) @(negedge clk);
        tests_run++;
        if (grant_log.size() == 0 || grant_log[0] != 0) begin
            tests_failed++;
            $display("FAIL post_reset_first_grant: got %p expected port 0 first", grant_log);
        end
        tests_run++;
        if (rsp_count - base !== 2) begin
            tests_failed++;
            $display("FAIL abandoned_job: got %0d responses expected 2", rsp_count - base);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        test_reset();
        test_fips_vector();
        test_round_robin();
        test_back_pressure();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t expected completion", $time);
        $fatal(1, "bench stalled");
    end

endmodule

// File: doc/aes_128_arbiter.md
AES_128_ARBITER -- requirements
Module: aes_128_arbiter

Interface
REQ-001 Parameters SHALL be:
- N_REQ, default 2: number of requester ports, minimum 2.
- TIMEOUT, default 32: watchdog limit in WAIT, in cycles.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  N_REQ  per-port request present.
- req_ready  out  N_REQ  per-port request accepted.
- req_data  in  N_REQ x 128  per-port plaintext.
- req_key  in  N_REQ x 128  per-port key.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  128  ciphertext.
- rsp_id  out  clog2(N_REQ)  index of the originating port.
- rsp_err  out  1  watchdog expiry; rsp_data is 0 when set.
- core_in_bus  out  128  to core in_bus.
- core_key  out  128  to core key.
- core_out_bus  in  128  from core out_bus.
- core_valid_ready  in  1  from core valid_ready.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The arbiter SHALL share one multicycle AES-128 core among N_REQ requesters, with at most one job outstanding.
REQ-004 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-005 In IDLE with any req_valid high, the arbiter SHALL:
- grant round-robin, starting the search at last_grant+1 modulo N_REQ;
- assert req_ready for the granted port only, for one cycle;
- latch data, key and id into holding registers;
- update last_grant;
- move to ISSUE on the next cycle.
REQ-006 req_ready SHALL be 0 in every state except the IDLE grant cycle, and SHALL never be high for more than one port.
REQ-007 A requester SHALL hold req_valid, req_data and req_key stable until req_ready; a port that drops req_valid before being granted is not served.
REQ-008 In ISSUE, WAIT and RESP, core_in_bus and core_key SHALL carry the holding registers unchanged; in IDLE they SHALL be 0.
REQ-009 In ISSUE, the arbiter SHALL stay until the first cycle with core_valid_ready=1, which is the core acceptance cycle, then move to WAIT with seen_low=0 and wd_cnt=0.
REQ-010 In WAIT, the arbiter SHALL:
- set seen_low when core_valid_ready=0;
- on the first cycle with core_valid_ready=1 and seen_low=1, capture core_out_bus into rsp_data with rsp_err=0, then move to RESP;
- count wd_cnt up by one per WAIT cycle.
REQ-011 If wd_cnt reaches TIMEOUT-1 without completion, the arbiter SHALL set rsp_err=1 and rsp_data=0, then move to RESP.
REQ-012 If completion and expiry happen in the same cycle, completion SHALL win.
REQ-013 In RESP, rsp_valid SHALL be 1, with rsp_data, rsp_id and rsp_err stable.
- On rsp_valid&&rsp_ready: move to IDLE.
- While rsp_ready=0: hold RESP indefinitely and grant no new request.
REQ-014 core_out_bus SHALL be ignored outside the WAIT capture cycle.
REQ-015 Minimum latency from req accept (cycle T) SHALL be: ISSUE at T+1, rsp_valid at core acceptance + core latency + 1.
REQ-016 The RESP->IDLE cycle SHALL NOT grant; the earliest next grant is the following cycle.

Reset
REQ-017 While rst is high, all of the following SHALL be forced immediately, regardless of clk:
- state=IDLE, last_grant=N_REQ-1 (so port 0 wins first);
- seen_low=0, wd_cnt=0;
- rsp_valid=0, rsp_err=0, rsp_data=0, rsp_id=0;
- req_ready=0, busy=0, core_in_bus=0, core_key=0.
REQ-018 Reset mid-operation SHALL abandon the job silently, with no response emitted; the core is reset by the same system reset.

Structure
REQ-019 Shared package aes_128_pkg SHALL hold:
- AES_BLOCK_W=128;
- the arb_state_t enum;
- default constants for N_REQ and TIMEOUT.
REQ-020 Round-robin selection SHALL live in one sub-module, rr_arbiter (inputs: request vector and last_grant; outputs: grant index and any-grant). The FSM, holding registers and watchdog SHALL stay in aes_128_arbiter.
REQ-021 aes_128_arbiter SHALL NOT instantiate the core; it connects to the core at the top level.

Verification
REQ-022 Port 0 sends key 000102030405060708090a0b0c0d0e0f with plaintext 00112233445566778899aabbccddeeff, attached to the real core -> rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, rsp_err=0.
REQ-023 Both ports hold req_valid continuously for 4 jobs after reset -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1; req_ready never high on both ports.
REQ-024 rsp_ready held 0 for 20 cycles during RESP -> rsp_valid stays 1, rsp_data stable, req_ready stays 0; a grant follows 2 cycles after rsp_ready rises.
REQ-025 Core model never returns core_valid_ready=1 after acceptance, TIMEOUT=32 -> RESP entered after 32 WAIT cycles with rsp_err=1, rsp_data=0.
REQ-026 rst pulsed mid-WAIT -> all outputs at reset values while rst is high, no response emitted, port 0 granted first after release.
